filter_biquad_section: RTL and testbench



---
 rtl/filter_biquad_section.sv | 209 ++++++++++++++++++++
 tb/tb_filter_biquad_section.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_biquad_section.sv
// -----------------------------------------------------------------------------
// filter_biquad_section
//
// One second-order IIR section (Direct Form II) with an input gain stage.
// A single shared multiplier walks a fixed schedule of six multiply states;
// the result is staged one extra cycle, so valid_out is seen 7 cycles after
// the capture edge. The section accepts its next sample 8 cycles after the
// previous one was captured.
//
// Handshake: valid_in is a one-cycle strobe sampled only while the section is
// idle with no result waiting to be published. A strobe at any other time is
// dropped silently. valid_out is a one-cycle strobe. audio_out, sat_gain and
// sat_accum change only in the cycle valid_out rises, and hold until the next
// result. There is no back-pressure.
//
// Ports
//   clk, rst_n        : clock, synchronous active-low reset
//   audio_in          : signed input sample x (AUDIO_BDEPTH bits)
//   valid_in          : strobe, audio_in valid
//   k                 : signed input gain, Q2.(COEF_BDEPTH-2)
//   a1, a2            : signed feedback coefficients (pre-negated, added)
//   b0, b1, b2        : signed feedforward coefficients
//   audio_out         : signed filtered sample y
//   valid_out         : strobe, new audio_out / flags
//   sat_gain          : gain stage clipped for this output sample
//   sat_accum         : recursion state or output clipped for this sample
// -----------------------------------------------------------------------------
module filter_biquad_section #(
  parameter int AUDIO_BDEPTH = 8,
  parameter int COEF_BDEPTH  = 16,
  parameter int GUARD_BITS   = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic signed [AUDIO_BDEPTH-1:0] audio_in,
  input  logic                           valid_in,
  input  logic signed [COEF_BDEPTH-1:0]  k,
  input  logic signed [COEF_BDEPTH-1:0]  a1,
  input  logic signed [COEF_BDEPTH-1:0]  a2,
  input  logic signed [COEF_BDEPTH-1:0]  b0,
  input  logic signed [COEF_BDEPTH-1:0]  b1,
  input  logic signed [COEF_BDEPTH-1:0]  b2,
  output logic signed [AUDIO_BDEPTH-1:0] audio_out,
  output logic                           valid_out,
  output logic                           sat_gain,
  output logic                           sat_accum
);

  localparam int A  = AUDIO_BDEPTH;
  localparam int C  = COEF_BDEPTH;
  localparam int F  = COEF_BDEPTH - 2;
  localparam int W  = AUDIO_BDEPTH + GUARD_BITS;
  localparam int PW = C + W;
  localparam int AW = C + W + 3;

  localparam logic signed [A-1:0] A_MAX = {1'b0, {(A-1){1'b1}}};
  localparam logic signed [A-1:0] A_MIN = {1'b1, {(A-1){1'b0}}};
  localparam logic signed [W-1:0] W_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] W_MIN = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, GAIN, FB1, FB2, FF0, FF1, FF2} state_t;

  state_t              state_q;
  logic signed [A-1:0] x_q;
  logic signed [C-1:0] k_q, a1_q, a2_q, b0_q, b1_q, b2_q;
  logic signed [W-1:0] w1_q, w2_q, w0_q;
  logic signed [A-1:0] g_q;
  logic                sat_g_q, sat_w_q;
  logic signed [AW-1:0] acc_q;
  // Finished result waiting one cycle before publication; also keeps the
  // section busy so the next capture lands no earlier than 8 cycles later.
  logic                pend_q;
  logic signed [A-1:0] res_y_q;
  logic                res_sg_q, res_sa_q;

  logic signed [C-1:0]  mul_c;
  logic signed [W-1:0]  mul_op;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] gain_sh;
  logic signed [AW-1:0] acc_fb1, acc_sum, acc_sh;
  logic signed [A-1:0]  g_d, y_d;
  logic signed [W-1:0]  w0_d;
  logic                 g_clip, w0_clip, y_clip;

  // Operand selection for the shared multiplier, one product per state.
  always_comb begin
    mul_c  = '0;
    mul_op = '0;
    case (state_q)
      GAIN:    begin mul_c = k_q;  mul_op = W'(x_q); end
      FB1:     begin mul_c = a1_q; mul_op = w1_q;    end
      FB2:     begin mul_c = a2_q; mul_op = w2_q;    end
      FF0:     begin mul_c = b0_q; mul_op = w0_q;    end
      FF1:     begin mul_c = b1_q; mul_op = w1_q;    end
      FF2:     begin mul_c = b2_q; mul_op = w2_q;    end
      default: begin mul_c = '0;   mul_op = '0;      end
    endcase
  end

  always_comb begin
    prod    = PW'(mul_c) * PW'(mul_op);
    gain_sh = prod >>> F;
    acc_fb1 = (AW'(g_q) <<< F) + AW'(prod);
    acc_sum = acc_q + AW'(prod);
    acc_sh  = acc_sum >>> F;

    g_d    = gain_sh[A-1:0];
    g_clip = 1'b0;
    if (gain_sh > PW'(A_MAX)) begin
      g_d = A_MAX; g_clip = 1'b1;
    end else if (gain_sh < PW'(A_MIN)) begin
      g_d = A_MIN; g_clip = 1'b1;
    end

    // acc_sh feeds both the state clamp (FB2) and the output clamp (FF2).
    w0_d    = acc_sh[W-1:0];
    w0_clip = 1'b0;
    if (acc_sh > AW'(W_MAX)) begin
      w0_d = W_MAX; w0_clip = 1'b1;
    end else if (acc_sh < AW'(W_MIN)) begin
      w0_d = W_MIN; w0_clip = 1'b1;
    end

    y_d    = acc_sh[A-1:0];
    y_clip = 1'b0;
    if (acc_sh > AW'(A_MAX)) begin
      y_d = A_MAX; y_clip = 1'b1;
    end else if (acc_sh < AW'(A_MIN)) begin
      y_d = A_MIN; y_clip = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      x_q       <= '0;
      k_q       <= '0; a1_q <= '0; a2_q <= '0;
      b0_q      <= '0; b1_q <= '0; b2_q <= '0;
      w0_q      <= '0; w1_q <= '0; w2_q <= '0;
      g_q       <= '0;
      sat_g_q   <= 1'b0;
      sat_w_q   <= 1'b0;
      acc_q     <= '0;
      pend_q    <= 1'b0;
      res_y_q   <= '0;
      res_sg_q  <= 1'b0;
      res_sa_q  <= 1'b0;
      audio_out <= '0;
      valid_out <= 1'b0;
      sat_gain  <= 1'b0;
      sat_accum <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      if (pend_q) begin
        audio_out <= res_y_q;
        sat_gain  <= res_sg_q;
        sat_accum <= res_sa_q;
        valid_out <= 1'b1;
        pend_q    <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (valid_in && !pend_q) begin
            x_q  <= audio_in;
            k_q  <= k;  a1_q <= a1; a2_q <= a2;
            b0_q <= b0; b1_q <= b1; b2_q <= b2;
            state_q <= GAIN;
          end
        end
        GAIN: begin
          g_q     <= g_d;
          sat_g_q <= g_clip;
          state_q <= FB1;
        end
        FB1: begin
          acc_q   <= acc_fb1;
          state_q <= FB2;
        end
        FB2: begin
          acc_q   <= acc_sum;
          w0_q    <= w0_d;
          sat_w_q <= w0_clip;
          state_q <= FF0;
        end
        FF0: begin
          acc_q   <= AW'(prod);
          state_q <= FF1;
        end
        FF1: begin
          acc_q   <= acc_sum;
          state_q <= FF2;
        end
        FF2: begin
          acc_q    <= acc_sum;
          res_y_q  <= y_d;
          res_sg_q <= sat_g_q;
          res_sa_q <= sat_w_q | y_clip;
          pend_q   <= 1'b1;
          w2_q     <= w1_q;
          w1_q     <= w0_q;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_filter_biquad_section.sv
// -----------------------------------------------------------------------------
// tb_filter_biquad_section
//
// Self-checking bench for filter_biquad_section at default parameters.
// The reference model computes each sample with 64-bit integer arithmetic
// straight from the filter equations and keeps its own w1/w2 history.
// -----------------------------------------------------------------------------
module tb_filter_biquad_section;

  localparam int F_TB = 14;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic signed [7:0]  audio_in;
  logic               valid_in;
  logic signed [15:0] k_r, a1_r, a2_r, b0_r, b1_r, b2_r;
  logic signed [7:0]  audio_out;
  logic               valid_out, sat_gain, sat_accum;

  filter_biquad_section dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .audio_in  (audio_in),
    .valid_in  (valid_in),
    .k         (k_r),
    .a1        (a1_r),
    .a2        (a2_r),
    .b0        (b0_r),
    .b1        (b1_r),
    .b2        (b2_r),
    .audio_out (audio_out),
    .valid_out (valid_out),
    .sat_gain  (sat_gain),
    .sat_accum (sat_accum)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  longint m_w1, m_w2;
  logic signed [7:0] exp_q[$];

  function automatic longint sat_n(input longint v, input int bits);
    longint hi, lo;
    hi = (longint'(1) <<< (bits - 1)) - 1;
    lo = -(longint'(1) <<< (bits - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic model_cur(input logic signed [7:0] x, output logic signed [7:0] ey,
                           output logic esg, output logic esa);
    longint p, gs, g, acc, w0u, w0, yu, yv;
    p   = longint'(k_r) * longint'(x);
    gs  = p >>> F_TB;
    g   = sat_n(gs, 8);
    esg = (g != gs);
    acc = (g <<< F_TB) + longint'(a1_r) * m_w1 + longint'(a2_r) * m_w2;
    w0u = acc >>> F_TB;
    w0  = sat_n(w0u, 16);
    yu  = (longint'(b0_r) * w0 + longint'(b1_r) * m_w1 + longint'(b2_r) * m_w2) >>> F_TB;
    yv  = sat_n(yu, 8);
    esa = (w0 != w0u) || (yv != yu);
    ey  = yv[7:0];
    m_w2 = m_w1;
    m_w1 = w0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_coefs(input int kk, ca1, ca2, cb0, cb1, cb2);
    k_r  = 16'(kk);  a1_r = 16'(ca1); a2_r = 16'(ca2);
    b0_r = 16'(cb0); b1_r = 16'(cb1); b2_r = 16'(cb2);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    valid_in = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_w1  = 0;
    m_w2  = 0;
  endtask

  // Sends one sample starting at a falling edge; returns the observed result,
  // its latency in cycles after the capture edge (-1 if none within budget),
  // and whether valid_out dropped again the following cycle.
  task automatic send(input logic signed [7:0] x, input bit scramble,
                      output logic signed [7:0] y, output logic sg, output logic sa,
                      output int lat, output bit single);
    logic signed [15:0] sk, sa1, sa2, sb0, sb1, sb2;
    sk = k_r; sa1 = a1_r; sa2 = a2_r; sb0 = b0_r; sb1 = b1_r; sb2 = b2_r;
    audio_in = x;
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    audio_in = 8'($urandom);
    if (scramble) begin
      k_r  = 16'($urandom); a1_r = 16'($urandom); a2_r = 16'($urandom);
      b0_r = 16'($urandom); b1_r = 16'($urandom); b2_r = 16'($urandom);
    end
    lat = -1;
    y = 'x; sg = 1'bx; sa = 1'bx;
    for (int n = 0; n <= 12; n++) begin
      @(negedge clk);
      if (valid_out === 1'b1) begin
        lat = n; y = audio_out; sg = sat_gain; sa = sat_accum;
        break;
      end
    end
    @(negedge clk);
    single = (valid_out === 1'b0);
    k_r = sk; a1_r = sa1; a2_r = sa2; b0_r = sb0; b1_r = sb1; b2_r = sb2;
  endtask

  // Drives up to three strobes at given cycle offsets (-1 = unused) and logs
  // every valid_out seen over ncyc cycles.
  int               hit_t[$];
  logic signed [7:0] hit_y[$];
  logic [1:0]       hit_f[$];

  task automatic drive_pattern(input int t0, t1, t2, input logic signed [7:0] x0, x1, x2,
                               input int ncyc);
    hit_t.delete(); hit_y.delete(); hit_f.delete();
    for (int t = 0; t < ncyc; t++) begin
      valid_in = (t == t0) || (t == t1) || (t == t2);
      audio_in = (t == t0) ? x0 : (t == t1) ? x1 : (t == t2) ? x2 : 8'($urandom);
      @(posedge clk);
      #1 valid_in = 1'b0;
      @(negedge clk);
      if (valid_out === 1'b1) begin
        hit_t.push_back(t);
        hit_y.push_back(audio_out);
        hit_f.push_back({sat_gain, sat_accum});
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic signed [7:0] y, ey;
    logic sg, sa, esg, esa;
    int lat;
    bit single;
    set_coefs(16384, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      valid_in = (i % 2 == 0);
      audio_in = 8'($urandom);
      @(negedge clk);
      checks++;
      if ({audio_out, valid_out, sat_gain, sat_accum} !== 11'b0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got y=%0d v=%b sg=%b sa=%b exp all 0",
                 i, audio_out, valid_out, sat_gain, sat_accum);
      end
    end
    valid_in = 1'b0;
    rst_n = 1'b1;
    m_w1 = 0; m_w2 = 0;
    set_coefs(12000, 9000, -5000, 10000, 7000, -6000);
    model_cur(8'sd77, ey, esg, esa);
    send(8'sd77, 1'b0, y, sg, sa, lat, single);
    checks++;
    if (lat !== 7 || !single || y !== ey || sg !== esg || sa !== esa) begin
      errors++;
      $display("FAIL reset_first got y=%0d sg=%b sa=%b lat=%0d single=%b exp y=%0d sg=%b sa=%b lat=7",
               y, sg, sa, lat, single, ey, esg, esa);
    end
  endtask

  task automatic test_passthrough();
    logic signed [7:0] xs[2];
    logic signed [7:0] exp_y[2];
    logic signed [7:0] y, ey;
    logic sg, sa, esg, esa;
    int lat;
    bit single;
    xs[0] = 8'sd120;  exp_y[0] = 8'sd120;
    xs[1] = -8'sd128; exp_y[1] = -8'sd128;
    do_reset();
    set_coefs(16384, 0, 0, 16384, 0, 0);
    for (int i = 0; i < 2; i++) begin
      model_cur(xs[i], ey, esg, esa);
      send(xs[i], 1'b0, y, sg, sa, lat, single);
      checks++;
      if (lat !== 7 || !single || y !== ey || y !== exp_y[i] || sg !== 1'b0 || sa !== 1'b0) begin
        errors++;
        $display("FAIL passthrough x=%0d got y=%0d sg=%b sa=%b lat=%0d exp y=%0d sg=0 sa=0 lat=7",
                 xs[i], y, sg, sa, lat, exp_y[i]);
      end
    end
  endtask

  task automatic test_pure_delay();
    logic signed [7:0] xs[4];
    logic signed [7:0] y, ey;
    logic sg, sa, esg, esa;
    int lat;
    bit single;
    xs[0] = 8'sd100; xs[1] = 8'sd0; xs[2] = 8'sd0; xs[3] = 8'sd0;
    do_reset();
    set_coefs(16384, 0, 0, 0, 0, 16384);
    exp_q.delete();
    exp_q.push_back(8'sd0); exp_q.push_back(8'sd0);
    exp_q.push_back(8'sd100); exp_q.push_back(8'sd0);
    for (int i = 0; i < 4; i++) begin
      model_cur(xs[i], ey, esg, esa);
      send(xs[i], 1'b0, y, sg, sa, lat, single);
      checks++;
      if (lat !== 7 || !single || y !== ey || y !== exp_q[i] || sg !== esg || sa !== esa) begin
        errors++;
        $display("FAIL pure_delay i=%0d got y=%0d lat=%0d exp y=%0d lat=7", i, y, lat, exp_q[i]);
      end
    end
  endtask

  task automatic test_gain_clip();
    logic signed [7:0] xs[2];
    logic signed [7:0] exp_y[2];
    logic signed [7:0] y, ey;
    logic sg, sa, esg, esa;
    int lat;
    bit single;
    xs[0] = 8'sd100;  exp_y[0] = 8'sd127;
    xs[1] = -8'sd100; exp_y[1] = -8'sd128;
    do_reset();
    set_coefs(32767, 0, 0, 16384, 0, 0);
    for (int i = 0; i < 2; i++) begin
      model_cur(xs[i], ey, esg, esa);
      send(xs[i], 1'b0, y, sg, sa, lat, single);
      checks++;
      if (lat !== 7 || !single || y !== ey || y !== exp_y[i] || sg !== 1'b1 || sa !== esa) begin
        errors++;
        $display("FAIL gain_clip x=%0d got y=%0d sg=%b sa=%b lat=%0d exp y=%0d sg=1 sa=%b",
                 xs[i], y, sg, sa, lat, exp_y[i], esa);
      end
    end
  endtask

  task automatic test_output_clip_ignore();
    logic signed [7:0] ey;
    logic esg, esa;
    do_reset();
    set_coefs(16384, 0, 0, 32767, 0, 0);
    model_cur(8'sd100, ey, esg, esa);
    drive_pattern(0, 3, -1, 8'sd100, -8'sd50, 8'sd0, 20);
    checks++;
    if (hit_t.size() != 1 || hit_t[0] != 7 || hit_y[0] !== ey || ey !== 8'sd127
        || hit_f[0] !== {esg, esa} || hit_f[0] !== 2'b01) begin
      errors++;
      $display("FAIL output_clip_ignore got hits=%0d t=%0d y=%0d f=%b exp hits=1 t=7 y=127 f=01",
               hit_t.size(), (hit_t.size() > 0) ? hit_t[0] : -1,
               (hit_y.size() > 0) ? hit_y[0] : 8'sd0, (hit_f.size() > 0) ? hit_f[0] : 2'bxx);
    end
  endtask

  task automatic test_back_to_back();
    logic signed [7:0] xa, xb, xc, ea, ec;
    logic fa_g, fa_s, fc_g, fc_s;
    do_reset();
    set_coefs(14000, 8000, -4000, 9000, 6000, 3000);
    xa = 8'($urandom); xb = 8'($urandom); xc = 8'($urandom);
    model_cur(xa, ea, fa_g, fa_s);
    model_cur(xc, ec, fc_g, fc_s);
    drive_pattern(0, 7, 8, xa, xb, xc, 24);
    checks++;
    if (hit_t.size() != 2 || hit_t[0] != 7 || hit_t[1] != 15 || hit_y[0] !== ea || hit_y[1] !== ec
        || hit_f[0] !== {fa_g, fa_s} || hit_f[1] !== {fc_g, fc_s}) begin
      errors++;
      $display("FAIL back_to_back got hits=%0d t0=%0d t1=%0d y0=%0d y1=%0d exp hits=2 t=7,15 y=%0d,%0d",
               hit_t.size(), (hit_t.size() > 0) ? hit_t[0] : -1, (hit_t.size() > 1) ? hit_t[1] : -1,
               (hit_y.size() > 0) ? hit_y[0] : 8'sd0, (hit_y.size() > 1) ? hit_y[1] : 8'sd0, ea, ec);
    end
  endtask

  task automatic test_abort();
    logic signed [7:0] x, y, ey;
    logic sg, sa, esg, esa;
    int lat, nvalid;
    bit single;
    do_reset();
    set_coefs(16384, 12000, -3000, 8000, 9000, 7000);
    for (int i = 0; i < 3; i++) begin
      x = 8'($urandom);
      model_cur(x, ey, esg, esa);
      send(x, 1'b0, y, sg, sa, lat, single);
    end
    audio_in = 8'sd90;
    valid_in = 1'b1;
    @(posedge clk);
    #1 valid_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_w1 = 0; m_w2 = 0;
    nvalid = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (valid_out === 1'b1) nvalid++;
    end
    checks++;
    if (nvalid != 0 || audio_out !== 8'sd0) begin
      errors++;
      $display("FAIL abort got valid_pulses=%0d y=%0d exp 0 0", nvalid, audio_out);
    end
    x = 8'sd55;
    model_cur(x, ey, esg, esa);
    send(x, 1'b0, y, sg, sa, lat, single);
    checks++;
    if (lat !== 7 || !single || y !== ey || sg !== esg || sa !== esa) begin
      errors++;
      $display("FAIL abort_after got y=%0d sg=%b sa=%b lat=%0d exp y=%0d sg=%b sa=%b lat=7",
               y, sg, sa, lat, ey, esg, esa);
    end
  endtask

  task automatic test_random();
    logic signed [7:0] x, y, ey;
    logic sg, sa, esg, esa;
    int lat;
    bit single;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      if (i % 2 == 0)
        set_coefs($urandom_range(0, 65535), $urandom_range(0, 65535), $urandom_range(0, 65535),
                  $urandom_range(0, 65535), $urandom_range(0, 65535), $urandom_range(0, 65535));
      else
        set_coefs($urandom_range(0, 32767) - 8192, $urandom_range(0, 16383) - 8192,
                  $urandom_range(0, 16383) - 8192, $urandom_range(0, 16383) - 8192,
                  $urandom_range(0, 16383) - 8192, $urandom_range(0, 16383) - 8192);
      x = 8'($urandom);
      model_cur(x, ey, esg, esa);
      send(x, 1'b1, y, sg, sa, lat, single);
      checks++;
      if (lat !== 7 || !single || y !== ey || sg !== esg || sa !== esa) begin
        errors++;
        $display("FAIL random i=%0d x=%0d got y=%0d sg=%b sa=%b lat=%0d exp y=%0d sg=%b sa=%b lat=7",
                 i, x, y, sg, sa, lat, ey, esg, esa);
      end
    end
  endtask

  task automatic test_resonator();
    logic signed [7:0] x, y, ey;
    logic sg, sa, esg, esa;
    int lat;
    bit single;
    do_reset();
    set_coefs(1838, 32600, -16280, 50, 0, -50);
    y = 8'sd0;
    for (int i = 0; i < 2000; i++) begin
      model_cur(8'sd120, ey, esg, esa);
      send(8'sd120, 1'b0, y, sg, sa, lat, single);
      checks++;
      if (lat !== 7 || !single || y !== ey || sg !== esg || sa !== esa) begin
        errors++;
        $display("FAIL resonator_dc i=%0d got y=%0d lat=%0d exp y=%0d lat=7", i, y, lat, ey);
      end
    end
    checks++;
    if (y > 8'sd2 || y < -8'sd2) begin
      errors++;
      $display("FAIL resonator_decay got y=%0d exp |y|<=2", y);
    end
    for (int i = 0; i < 808; i++) begin
      x = ((i / 101) % 2 == 0) ? -8'sd120 : 8'sd120;
      model_cur(x, ey, esg, esa);
      send(x, 1'b0, y, sg, sa, lat, single);
      checks++;
      if (lat !== 7 || !single || y !== ey || sg !== esg || sa !== esa) begin
        errors++;
        $display("FAIL resonator_square i=%0d got y=%0d lat=%0d exp y=%0d lat=7", i, y, lat, ey);
      end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    rst_n    = 1'b0;
    valid_in = 1'b0;
    audio_in = '0;
    m_w1 = 0;
    m_w2 = 0;
    set_coefs(0, 0, 0, 0, 0, 0);
    test_reset();
    test_passthrough();
    test_pure_delay();
    test_gain_clip();
    test_output_clip_ignore();
    test_back_to_back();
    test_abort();
    test_random();
    test_resonator();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
